// File: rtl/mcb_port_pkg.sv
// rtl/mcb_port_pkg.sv - shared constants and types for the MCB port-0 BRAM responder
//
// Purpose : instruction encodings, engine state enum and bus width constants
//           used by mcb_port_bram and its testbench.
// Ports   : none (package).
package mcb_port_pkg;

  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int ADDR_W = 30;

  localparam logic [2:0] INSTR_WR   = 3'b000;
  localparam logic [2:0] INSTR_RD   = 3'b001;
  localparam logic [2:0] INSTR_WRPC = 3'b010;
  localparam logic [2:0] INSTR_RDPC = 3'b011;

  typedef enum logic [1:0] {
    ST_CAL,
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
//
// Purpose : generic FWFT FIFO. A push into a full FIFO is dropped unless a pop
//           happens in the same cycle; a pop from an empty FIFO is a no-op.
// Ports   : clk, rst (async active-low)
//           push, push_data  - write side
//           pop, head        - read side; head is 0 while empty
//           count            - occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  // Stale storage is hidden so the head reads 0 after reset or a flush.
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcb_port_bram.sv
// rtl/mcb_port_bram.sv - MCB user port 0 responder backed by an on-chip 128-bit BRAM
//
// Purpose : stands in for the memory controller's port 0. Burst write and read
//           commands are queued and executed in order against an inferred BRAM.
// Ports   : clk, rst (async active-low), calib_done
//           cmd_en/cmd_instr/cmd_bl/cmd_byte_addr, cmd_empty/cmd_full
//           wr_en/wr_mask/wr_data, wr_full/wr_empty/wr_count, wr_underrun/wr_error
//           rd_en, rd_data (FWFT head), rd_full/rd_empty/rd_count, rd_overflow/rd_error
module mcb_port_bram
  import mcb_port_pkg::*;
#(
  parameter int AW         = 10,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 64,
  parameter int CAL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              calib_done,
  input  logic              cmd_en,
  input  logic [2:0]        cmd_instr,
  input  logic [5:0]        cmd_bl,
  input  logic [ADDR_W-1:0] cmd_byte_addr,
  output logic              cmd_empty,
  output logic              cmd_full,
  input  logic              wr_en,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              wr_empty,
  output logic [6:0]        wr_count,
  output logic              wr_underrun,
  output logic              wr_error,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_full,
  output logic              rd_empty,
  output logic [6:0]        rd_count,
  output logic              rd_overflow,
  output logic              rd_error
);

  localparam int CMD_W = 3 + 6 + AW;
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int DCW   = $clog2(DATA_DEPTH) + 1;
  localparam int CALW  = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
  localparam logic [CCW-1:0]  CMD_FULL  = CCW'(CMD_DEPTH);
  localparam logic [DCW-1:0]  DATA_FULL = DCW'(DATA_DEPTH);
  localparam logic [CALW-1:0] CAL_LAST  = CALW'(CAL_CYCLES - 1);

  state_t state, state_n;

  logic [CMD_W-1:0]         cmd_head;
  logic [CCW-1:0]           cmd_cnt;
  logic [MASK_W+DATA_W-1:0] wr_head;
  logic [DCW-1:0]           wr_cnt;
  logic [DCW-1:0]           rd_cnt;

  logic [2:0]        head_instr;
  logic [5:0]        head_bl;
  logic [AW-1:0]     head_addr;
  logic              head_is_wr;
  logic              head_is_rd;

  logic [CALW-1:0]   cal_cnt;
  logic [AW-1:0]     addr;
  logic [5:0]        remaining;
  logic [DATA_W-1:0] last_data;
  logic [MASK_W-1:0] last_mask;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic [DATA_W-1:0] bram_q;
  logic              rd_inflight;
  logic              rd_space;

  logic cmd_pop;
  logic wr_pop;
  logic bram_we;
  logic bram_re;

  // Byte offset and the address bits above the BRAM are not used.
  logic unused;
  assign unused = ^{cmd_byte_addr[ADDR_W-1:AW+4], cmd_byte_addr[3:0]};

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_en),
    .push_data ({cmd_instr, cmd_bl, cmd_byte_addr[AW+3:4]}),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .count     (cmd_cnt)
  );

  sync_fifo #(.WIDTH(MASK_W+DATA_W), .DEPTH(DATA_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data ({wr_mask, wr_data}),
    .pop       (wr_pop),
    .head      (wr_head),
    .count     (wr_cnt)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (bram_q),
    .pop       (rd_en),
    .head      (rd_data),
    .count     (rd_cnt)
  );

  assign cmd_empty   = (cmd_cnt == '0);
  assign cmd_full    = (cmd_cnt == CMD_FULL);
  assign wr_empty    = (wr_cnt == '0);
  assign wr_full     = (wr_cnt == DATA_FULL);
  assign wr_count    = wr_cnt;
  assign rd_empty    = (rd_cnt == '0);
  assign rd_full     = (rd_cnt == DATA_FULL);
  assign rd_count    = rd_cnt;
  assign rd_overflow = 1'b0;
  assign calib_done  = (state != ST_CAL);

  assign head_instr = cmd_head[CMD_W-1 -: 3];
  assign head_bl    = cmd_head[AW +: 6];
  assign head_addr  = cmd_head[AW-1:0];
  assign head_is_wr = (head_instr == INSTR_WR) || (head_instr == INSTR_WRPC);
  assign head_is_rd = (head_instr == INSTR_RD) || (head_instr == INSTR_RDPC);

  // Counting the word already on its way from the BRAM keeps the read FIFO
  // from ever being pushed while full.
  assign rd_space = (rd_cnt + DCW'(rd_inflight)) < DATA_FULL;

  // An empty write FIFO replays the last word taken from it.
  assign wdata = wr_empty ? last_data : wr_head[DATA_W-1:0];
  assign wmask = wr_empty ? last_mask : wr_head[DATA_W +: MASK_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CAL;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    cmd_pop = 1'b0;
    wr_pop  = 1'b0;
    bram_we = 1'b0;
    bram_re = 1'b0;
    case (state)
      ST_CAL: begin
        if (cal_cnt == CAL_LAST) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          if (head_is_wr)      state_n = ST_WRITE;
          else if (head_is_rd) state_n = ST_READ;
        end
      end
      ST_WRITE: begin
        wr_pop  = 1'b1;
        bram_we = 1'b1;
        if (remaining == '0) state_n = ST_IDLE;
      end
      ST_READ: begin
        if (rd_space) begin
          bram_re = 1'b1;
          if (remaining == '0) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cal_cnt     <= '0;
      addr        <= '0;
      remaining   <= '0;
      last_data   <= '0;
      last_mask   <= '0;
      rd_inflight <= 1'b0;
      wr_underrun <= 1'b0;
      wr_error    <= 1'b0;
      rd_error    <= 1'b0;
    end else begin
      if ((state == ST_CAL) && (cal_cnt != CAL_LAST)) cal_cnt <= cal_cnt + CALW'(1);
      if (cmd_pop) begin
        addr      <= head_addr;
        remaining <= head_bl;
      end else if (bram_we || bram_re) begin
        addr      <= addr + AW'(1);
        remaining <= remaining - 6'd1;
      end
      if (bram_we && !wr_empty) begin
        last_data <= wr_head[DATA_W-1:0];
        last_mask <= wr_head[DATA_W +: MASK_W];
      end
      if (bram_we && wr_empty) wr_underrun <= 1'b1;
      if (wr_en && wr_full)    wr_error    <= 1'b1;
      if (rd_en && rd_empty)   rd_error    <= 1'b1;
      rd_inflight <= bram_re;
    end
  end

  // Single-port BRAM; its contents survive reset.
  logic [DATA_W-1:0] bram [2**AW];

  always_ff @(posedge clk) begin
    if (bram_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wmask[b]) bram[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (bram_re) bram_q <= bram[addr];
  end

endmodule

// File: tb/tb_mcb_port_bram.sv
// tb/tb_mcb_port_bram.sv - directed self-checking bench for mcb_port_bram
//
// Purpose : drives calibration, burst write/read, byte masks, address wrap,
//           backpressure, error flags, underrun and mid-burst reset.
// Ports   : none (top-level bench).
module tb_mcb_port_bram;
  import mcb_port_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         calib_done;
  logic         cmd_en;
  logic [2:0]   cmd_instr;
  logic [5:0]   cmd_bl;
  logic [29:0]  cmd_byte_addr;
  logic         cmd_empty, cmd_full;
  logic         wr_en;
  logic [15:0]  wr_mask;
  logic [127:0] wr_data;
  logic         wr_full, wr_empty;
  logic [6:0]   wr_count;
  logic         wr_underrun, wr_error;
  logic         rd_en;
  logic [127:0] rd_data;
  logic         rd_full, rd_empty;
  logic [6:0]   rd_count;
  logic         rd_overflow, rd_error;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  mcb_port_bram #(.AW(10), .CMD_DEPTH(4), .DATA_DEPTH(64), .CAL_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
    .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] a);
    cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = a;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [127:0] d, input logic [15:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [127:0] pat(input int k);
    pat = {32'hB0B0_0000 + 32'(k), 64'h0123_4567_89AB_CDEF, 32'(k)};
  endfunction

  function automatic logic [127:0] uword(input int k);
    uword = {4{32'hFACE_0000 + 32'(k)}};
  endfunction

  // Asserts reset asynchronously, checks every output before any clock edge,
  // then releases it right after an edge so calibration counts from there.
  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({calib_done, cmd_full, wr_full, rd_full} !== 4'b0000) begin
      errors++; $display("FAIL reset_full_calib: got %b required 0000", {calib_done, cmd_full, wr_full, rd_full});
    end
    checks++;
    if ({cmd_empty, wr_empty, rd_empty} !== 3'b111) begin
      errors++; $display("FAIL reset_empty: got %b required 111", {cmd_empty, wr_empty, rd_empty});
    end
    checks++;
    if ({wr_count, rd_count} !== 14'd0) begin
      errors++; $display("FAIL reset_counts: wr_count %0d rd_count %0d required 0 0", wr_count, rd_count);
    end
    checks++;
    if ({wr_underrun, wr_error, rd_error, rd_overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_sticky: got %b required 0000", {wr_underrun, wr_error, rd_error, rd_overflow});
    end
    checks++;
    if (rd_data !== 128'd0) begin
      errors++; $display("FAIL reset_rd_data: got %h required 0", rd_data);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_calib();
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (calib_done !== (k >= 16)) begin
        errors++; $display("FAIL calib_done_edge%0d: got %b required %b", k, calib_done, (k >= 16));
      end
      checks++;
      if (rd_empty !== (k < 19)) begin
        errors++; $display("FAIL calib_rd_empty_edge%0d: got %b required %b", k, rd_empty, (k < 19));
      end
      if (k == 10) begin
        checks++;
        if (cmd_empty !== 1'b0) begin
          errors++; $display("FAIL calib_cmd_held: cmd_empty got %b required 0", cmd_empty);
        end
      end
      if (k == 2) begin
        cmd_en = 1'b1; cmd_instr = INSTR_RD; cmd_bl = 6'd0; cmd_byte_addr = 30'h0;
      end
      if (k == 3) cmd_en = 1'b0;
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if ({rd_empty, rd_count, rd_error} !== {1'b1, 7'd0, 1'b0}) begin
      errors++; $display("FAIL calib_pop: rd_empty %b rd_count %0d rd_error %b required 1 0 0", rd_empty, rd_count, rd_error);
    end
  endtask

  task automatic test_write_read();
    int got, guard;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      push_wr({96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'(i)}, 16'h0000);
      exp_q.push_back({96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'(i)});
    end
    push_cmd(INSTR_WR, 6'd15, 30'h100);
    checks++;
    if (wr_count !== 7'd16) begin
      errors++; $display("FAIL wl_after_T: wr_count got %0d required 16", wr_count);
    end
    tick();
    checks++;
    if (wr_count !== 7'd16) begin
      errors++; $display("FAIL wl_after_T1: wr_count got %0d required 16", wr_count);
    end
    tick();
    checks++;
    if (wr_count !== 7'd15) begin
      errors++; $display("FAIL wl_after_T2: wr_count got %0d required 15", wr_count);
    end
    push_cmd(INSTR_RD, 6'd15, 30'h100);
    guard = 0;
    while (rd_empty && guard < 200) begin tick(); guard++; end
    got = 0; guard = 0;
    while (got < exp_q.size() && guard < 100) begin
      if (!rd_empty) begin
        checks++;
        if (rd_data !== exp_q[got]) begin
          errors++; $display("FAIL wr_rd_word%0d: got %h required %h", got, rd_data, exp_q[got]);
        end
        got++; rd_en = 1'b1;
      end else rd_en = 1'b0;
      tick(); guard++;
    end
    rd_en = 1'b0;
    checks++;
    if (got != 16 || guard != 16) begin
      errors++; $display("FAIL wr_rd_stream: words %0d in %0d cycles required 16 in 16", got, guard);
    end
    checks++;
    if ({rd_empty, wr_empty} !== 2'b11) begin
      errors++; $display("FAIL wr_rd_drained: rd_empty/wr_empty got %b required 11", {rd_empty, wr_empty});
    end
  endtask

  task automatic test_byte_mask();
    int guard;
    push_wr({128{1'b1}}, 16'h0000);
    push_cmd(INSTR_WR, 6'd0, 30'h50);
    push_wr(128'd0, 16'hFFFE);
    push_cmd(INSTR_WRPC, 6'd0, 30'h50);
    push_cmd(3'b100, 6'd63, 30'h50);
    push_cmd(INSTR_RDPC, 6'd0, 30'h50);
    guard = 0;
    while (rd_empty && guard < 100) begin tick(); guard++; end
    repeat (3) tick();
    checks++;
    if (rd_data !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00) begin
      errors++; $display("FAIL mask_data: got %h required ffff_..._ff00", rd_data);
    end
    checks++;
    if ({rd_count, cmd_empty} !== {7'd1, 1'b1}) begin
      errors++; $display("FAIL mask_ignored_cmd: rd_count %0d cmd_empty %b required 1 1", rd_count, cmd_empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_addr_wrap();
    int got, guard;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_wr({4{32'hC0DE_0000 + 32'(i)}}, 16'h0000);
    push_cmd(INSTR_WR, 6'd3, 30'h3FE0);
    push_cmd(INSTR_RD, 6'd1, 30'h3000_400F);
    push_cmd(INSTR_RD, 6'd1, 30'h3FE0);
    exp_q.push_back({4{32'hC0DE_0002}});
    exp_q.push_back({4{32'hC0DE_0003}});
    exp_q.push_back({4{32'hC0DE_0000}});
    exp_q.push_back({4{32'hC0DE_0001}});
    got = 0; guard = 0;
    while (got < exp_q.size() && guard < 200) begin
      if (!rd_empty) begin
        checks++;
        if (rd_data !== exp_q[got]) begin
          errors++; $display("FAIL wrap_word%0d: got %h required %h", got, rd_data, exp_q[got]);
        end
        got++; rd_en = 1'b1;
      end else rd_en = 1'b0;
      tick(); guard++;
    end
    rd_en = 1'b0;
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL wrap_timeout: got %0d words required 4", got);
    end
  endtask

  task automatic test_backpressure();
    int got, guard;
    exp_q.delete();
    for (int i = 0; i < 64; i++) push_wr(pat(i), 16'h0000);
    checks++;
    if ({wr_full, wr_count, wr_error} !== {1'b1, 7'd64, 1'b0}) begin
      errors++; $display("FAIL wr_full: full %b count %0d error %b required 1 64 0", wr_full, wr_count, wr_error);
    end
    push_wr(128'h5555, 16'h0000);
    checks++;
    if ({wr_count, wr_error} !== {7'd64, 1'b1}) begin
      errors++; $display("FAIL wr_error: count %0d error %b required 64 1", wr_count, wr_error);
    end
    push_cmd(INSTR_WR, 6'd63, 30'h400);
    push_cmd(INSTR_RD, 6'd63, 30'h400);
    push_cmd(INSTR_RD, 6'd63, 30'h400);
    for (int r = 0; r < 2; r++) for (int i = 0; i < 64; i++) exp_q.push_back(pat(i));
    guard = 0;
    while (rd_count != 7'd64 && guard < 400) begin tick(); guard++; end
    repeat (10) tick();
    checks++;
    if ({rd_count, rd_full, rd_overflow} !== {7'd64, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_saturate: count %0d full %b overflow %b required 64 1 0", rd_count, rd_full, rd_overflow);
    end
    got = 0; guard = 0;
    while (got < exp_q.size() && guard < 1000) begin
      if (!rd_empty) begin
        checks++;
        if (rd_data !== exp_q[got]) begin
          errors++; $display("FAIL bp_word%0d: got %h required %h", got, rd_data, exp_q[got]);
        end
        got++; rd_en = 1'b1;
      end else rd_en = 1'b0;
      tick(); guard++;
    end
    rd_en = 1'b0;
    checks++;
    if (got != 128 || rd_overflow !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %0d words overflow %b required 128 0", got, rd_overflow);
    end
    checks++;
    if (rd_error !== 1'b0) begin
      errors++; $display("FAIL rd_error_pre: got %b required 0", rd_error);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if ({rd_error, rd_count} !== {1'b1, 7'd0}) begin
      errors++; $display("FAIL rd_error_set: error %b count %0d required 1 0", rd_error, rd_count);
    end
  endtask

  task automatic test_underrun_reset();
    int got, guard;
    checks++;
    if (wr_underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_pre: got %b required 0", wr_underrun);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_wr(uword(i), 16'h0000);
    push_cmd(INSTR_WR, 6'd7, 30'hC80);
    repeat (12) tick();
    checks++;
    if ({wr_underrun, wr_empty} !== 2'b11) begin
      errors++; $display("FAIL underrun_set: underrun/empty got %b required 11", {wr_underrun, wr_empty});
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(uword((i < 4) ? i : 3));
    push_cmd(INSTR_RD, 6'd7, 30'hC80);
    got = 0; guard = 0;
    while (got < exp_q.size() && guard < 200) begin
      if (!rd_empty) begin
        checks++;
        if (rd_data !== exp_q[got]) begin
          errors++; $display("FAIL underrun_word%0d: got %h required %h", got, rd_data, exp_q[got]);
        end
        got++; rd_en = 1'b1;
      end else rd_en = 1'b0;
      tick(); guard++;
    end
    rd_en = 1'b0;
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL underrun_timeout: got %0d words required 8", got);
    end
    push_wr(pat(7), 16'h0000);
    push_wr(pat(8), 16'h0000);
    push_cmd(INSTR_RD, 6'd63, 30'h400);
    repeat (8) tick();
    checks++;
    if ({rd_empty, wr_count} !== {1'b0, 7'd2}) begin
      errors++; $display("FAIL midburst_state: rd_empty %b wr_count %0d required 0 2", rd_empty, wr_count);
    end
    test_reset();
    for (int i = 0; i < 5; i++) push_cmd(3'b111, 6'd0, 30'h0);
    checks++;
    if ({cmd_full, calib_done} !== 2'b10) begin
      errors++; $display("FAIL cal_cmd_full: full/calib got %b required 10", {cmd_full, calib_done});
    end
    repeat (30) tick();
    checks++;
    if ({cmd_empty, rd_empty, calib_done} !== 3'b111) begin
      errors++; $display("FAIL recal_idle: cmd_empty/rd_empty/calib got %b required 111", {cmd_empty, rd_empty, calib_done});
    end
    push_cmd(INSTR_RD, 6'd0, 30'hC80);
    guard = 0;
    while (rd_empty && guard < 50) begin tick(); guard++; end
    checks++;
    if (rd_data !== uword(0)) begin
      errors++; $display("FAIL bram_retained: got %h required %h", rd_data, uword(0));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    cmd_en = 1'b0; cmd_instr = 3'b0; cmd_bl = 6'd0; cmd_byte_addr = 30'h0;
    wr_en = 1'b0; wr_mask = 16'h0; wr_data = 128'd0; rd_en = 1'b0;
    #2;
    test_reset();
    test_calib();
    test_write_read();
    test_byte_mask();
    test_addr_wrap();
    test_backpressure();
    test_underrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
